// File: rtl/real_param_tx.sv
// real_param_tx: streams an elaboration-time real as a header, its IEEE-754
// words, a saturated fixed-point image and an XOR checksum over valid/ready.
module real_param_tx #(
  parameter real VALUE  = 2.0,
  parameter int  WORD_W = 16,
  parameter int  FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [WORD_W-1:0] tx_data_o,
  output logic              tx_last_o,
  output logic              done_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int NW = 64 / WORD_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_BITS = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  if (WORD_W != 8 && WORD_W != 16 &&
      WORD_W != 32 && WORD_W != 64) begin : g_bad_w
    $error("real_param_tx: WORD_W must be 8, 16, 32 or 64");
  end
  if (FRAC < 0 || FRAC >= WORD_W) begin : g_bad_frac
    $error("real_param_tx: FRAC must be in 0..WORD_W-1");
  end

  // Truncate toward zero after saturating in the real domain,
  // so wide words never overflow the integer conversion.
  function automatic logic [63:0] fix_img();
    real    s;
    real    lim;
    longint t;
    s   = VALUE * (2.0 ** FRAC);
    lim = 2.0 ** (WORD_W - 1);
    if (s >= lim)
      return 64'((longint'(1) << (WORD_W - 1)) - 1);
    if (s <= -lim)
      return 64'(-(longint'(1) << (WORD_W - 1)));
    t = longint'(s);
    if (s >= 0.0 && real'(t) > s) t = t - 1;
    if (s < 0.0 && real'(t) < s) t = t + 1;
    return 64'(t);
  endfunction

  localparam logic [63:0]       BITS     = $realtobits(VALUE);
  localparam logic [63:0]       FIX64    = fix_img();
  localparam logic [WORD_W-1:0] FIX_W    = FIX64[WORD_W-1:0];
  localparam logic [WORD_W-1:0] HDR_W    = WORD_W'(NW + 3);
  localparam logic [3:0]        IDX_LAST = 4'(NW - 1);

  function automatic logic [WORD_W-1:0] bits_word(
    input logic [3:0] i
  );
    logic [63:0] sh;
    sh = BITS << (WORD_W * int'(i));
    return sh[63 -: WORD_W];
  endfunction

  logic [2:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              xfer;

  assign xfer = valid_q && tx_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_HDR;
          valid_d = 1'b1;
          data_d  = HDR_W;
          busy_d  = 1'b1;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          csum_d  = csum_q ^ data_q;
          state_d = S_BITS;
          data_d  = bits_word(4'd0);
          idx_d   = '0;
        end
      end
      S_BITS: begin
        if (xfer) begin
          csum_d = csum_q ^ data_q;
          if (idx_q == IDX_LAST) begin
            state_d = S_FIX;
            data_d  = FIX_W;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = bits_word(idx_q + 4'd1);
          end
        end
      end
      S_FIX: begin
        if (xfer) begin
          csum_d  = csum_q ^ data_q;
          state_d = S_CSUM;
          data_d  = csum_q ^ data_q;
          last_d  = 1'b1;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          data_d  = '0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign tx_valid_o  = valid_q;
  assign tx_data_o   = data_q;
  assign tx_last_o   = last_q;
  assign done_o      = done_q;
  assign frame_cnt_o = cnt_q;

endmodule
